beacon_key_scheduler: RTL and testbench
=======================================

# beacon_key_scheduler

Time-shares the Morse keying output between up to N_REQ message sources. It sits between the requesting message banks and the transmitter key line. For each granted request it walks the granted bank's message ROM one bit per dot unit at a programmable dot rate, then holds the key off for a fixed inter-message gap. Arbitration is round-robin, so each bank repeats its message fairly without one source monopolising the key.

## Interface
- N_REQ, 4: number of requesters/message banks (2..8).
- ADDR_W, 6: message ROM address width (bits per message ≤ 2^ADDR_W).
- DIV_W, 20: width of dot-unit divider.
- GAP_UNITS, 7: dot units of forced key-off after each message (≥1).

- morse_clk  in  1  single clock; all logic on posedge.
- sys_rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  level request per bank; bit i = bank i wants to send.
- dot_div  in  DIV_W  clocks per dot unit minus 1.
- msg_last  in  ADDR_W  last bit address of a message (length = msg_last+1).
- rom_q  in  1  message bit from the selected bank's ROM (combinational on rom_sel/rom_addr).
- grant  out  N_REQ  one-hot owner of the key; all zero when idle.
- rom_sel  out  clog2(N_REQ)  binary index of granted bank.
- rom_addr  out  ADDR_W  current message bit address.
- key  out  1  registered transmitter key (1 = carrier on).
- busy  out  1  high in SEND or GAP.
- done  out  1  one-cycle pulse at message+gap completion.

## Operation
- Reset values: state IDLE, grant 0, rom_sel 0, rom_addr 0, key 0, busy 0, done 0, divider 0, gap counter 0, RR pointer N_REQ-1 (bank 0 wins first).
- States: IDLE, SEND, GAP.
- IDLE: if req≠0, pick first set bit searching upward from pointer+1, wrapping; register grant/rom_sel, set pointer to winner, rom_addr←0, divider←0, latch dot_div and msg_last, →SEND. If req=0 stay.
- Divider: counts 0..latched dot_div; tick when count = latched dot_div, then count←0. Runs only in SEND/GAP.
- SEND: on tick, if rom_addr = latched msg_last →GAP (gap count←0), else rom_addr+1.
- GAP: on tick, gap count+1; on the tick where gap count = GAP_UNITS-1 →IDLE, grant←0, done←1, rom_addr←0.
- key: registered, key←rom_q when state=SEND, else 0.
- busy is high exactly when state ≠ IDLE.
- req deasserted mid-message: ignored; message and gap complete. Other reqs during SEND/GAP wait.
- dot_div/msg_last changes mid-message take effect at next grant only.
- dot_div=0: one clock per bit; msg_last=0: single-bit message.
- sys_rst at any cycle returns everything to reset values at the next edge; key drops without completing the gap.

## Timing
- Request→grant: req set in IDLE at cycle t → grant/rom_sel valid at t+1 (=G).
- Bit k (0..msg_last) is on rom_addr during cycles G+k·(D+1) .. G+(k+1)·(D+1)-1, D = latched dot_div; key shows it one cycle later.
- done=1 and grant=0 in cycle G+(msg_last+1+GAP_UNITS)·(D+1); busy=0 same cycle.
- Next grant earliest one cycle after done cycle.
- key is 0 for at least GAP_UNITS·(D+1)-1 cycles between messages.

## Test plan
- Reset: hold sys_rst 3 cycles with req=4'b1111 → all outputs 0; release → grant=4'b0001 next cycle.
- Single message: req=4'b0010, dot_div=3, msg_last=7, ROM bits 8'b01110101 (LSB first) → key sequence 1,0,1,0,1,1,1,0 each 4 cycles starting G+1; done at G+60.
- Round-robin: req=4'b1111 held → grants 0001,0010,0100,1000,0001, each 61 cycles apart.
- Withdraw: drop req mid-SEND → message finishes, done pulses at planned cycle, no regrant.
- Mid-message reset: assert sys_rst at G+20 → key, grant, busy 0 next edge; rearbitration picks bank 0.
- Edge: dot_div=0, msg_last=0, GAP_UNITS=7 → key high 1 cycle if bit=1, done at G+8.

Source files
------------

// File: rtl/beacon_key_scheduler.sv
// Round-robin Morse keying scheduler: grants one message bank at a time, walks its
// ROM one bit per dot unit, then forces a fixed key-off gap before rearbitrating.
module beacon_key_scheduler #(
    parameter int N_REQ     = 4,
    parameter int ADDR_W    = 6,
    parameter int DIV_W     = 20,
    parameter int GAP_UNITS = 7
) (
    input  logic                     morse_clk,
    input  logic                     sys_rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [DIV_W-1:0]         dot_div,
    input  logic [ADDR_W-1:0]        msg_last,
    input  logic                     rom_q,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] rom_sel,
    output logic [ADDR_W-1:0]        rom_addr,
    output logic                     key,
    output logic                     busy,
    output logic                     done
);

    localparam int SEL_W = $clog2(N_REQ);
    localparam int GAP_W = $clog2(GAP_UNITS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   ptr, ptr_nxt;
    logic [N_REQ-1:0]   grant_nxt;
    logic [SEL_W-1:0]   rom_sel_nxt;
    logic [ADDR_W-1:0]  rom_addr_nxt;
    logic [DIV_W-1:0]   div_cnt, div_cnt_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_nxt;
    logic [DIV_W-1:0]   dot_lat, dot_lat_nxt;
    logic [ADDR_W-1:0]  last_lat, last_lat_nxt;
    logic               key_nxt;
    logic               done_nxt;
    logic               tick;
    logic               win_found;
    logic [SEL_W-1:0]   win_idx;
    logic [SEL_W-1:0]   cand;
    int                 cand_int;

    // Search upward from the bank after the last winner, wrapping, so every bank gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        cand_int  = 0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand_int = int'(ptr) + off;
            if (cand_int >= N_REQ) begin
                cand_int = cand_int - N_REQ;
            end
            cand = SEL_W'(cand_int);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign tick = (div_cnt == dot_lat);
    assign busy = (state != IDLE);

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        grant_nxt    = grant;
        rom_sel_nxt  = rom_sel;
        rom_addr_nxt = rom_addr;
        div_cnt_nxt  = div_cnt;
        gap_cnt_nxt  = gap_cnt;
        dot_lat_nxt  = dot_lat;
        last_lat_nxt = last_lat;
        done_nxt     = 1'b0;
        key_nxt      = (state == SEND) ? rom_q : 1'b0;

        if (state != IDLE) begin
            div_cnt_nxt = tick ? '0 : div_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                if (win_found) begin
                    grant_nxt    = N_REQ'(1) << win_idx;
                    rom_sel_nxt  = win_idx;
                    ptr_nxt      = win_idx;
                    rom_addr_nxt = '0;
                    div_cnt_nxt  = '0;
                    dot_lat_nxt  = dot_div;
                    last_lat_nxt = msg_last;
                    state_nxt    = SEND;
                end
            end
            SEND: begin
                if (tick) begin
                    if (rom_addr == last_lat) begin
                        gap_cnt_nxt = '0;
                        state_nxt   = GAP;
                    end else begin
                        rom_addr_nxt = rom_addr + 1'b1;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (gap_cnt == GAP_W'(GAP_UNITS - 1)) begin
                        gap_cnt_nxt  = '0;
                        grant_nxt    = '0;
                        rom_addr_nxt = '0;
                        done_nxt     = 1'b1;
                        state_nxt    = IDLE;
                    end else begin
                        gap_cnt_nxt = gap_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge morse_clk) begin
        if (sys_rst) begin
            state    <= IDLE;
            ptr      <= SEL_W'(N_REQ - 1);
            grant    <= '0;
            rom_sel  <= '0;
            rom_addr <= '0;
            div_cnt  <= '0;
            gap_cnt  <= '0;
            dot_lat  <= '0;
            last_lat <= '0;
            key      <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            grant    <= grant_nxt;
            rom_sel  <= rom_sel_nxt;
            rom_addr <= rom_addr_nxt;
            div_cnt  <= div_cnt_nxt;
            gap_cnt  <= gap_cnt_nxt;
            dot_lat  <= dot_lat_nxt;
            last_lat <= last_lat_nxt;
            key      <= key_nxt;
            done     <= done_nxt;
        end
    end

endmodule

// File: tb/tb_beacon_key_scheduler.sv
// Directed bench for beacon_key_scheduler: a cycle-timeline model predicts every output,
// and literal expectations taken from hand-worked schedules pin that model down.
module tb_beacon_key_scheduler;

    localparam int N_REQ     = 4;
    localparam int ADDR_W    = 6;
    localparam int DIV_W     = 20;
    localparam int GAP_UNITS = 7;

    logic              morse_clk;
    logic              sys_rst;
    logic [3:0]        req;
    logic [DIV_W-1:0]  dot_div;
    logic [ADDR_W-1:0] msg_last;
    logic              rom_q;
    logic [3:0]        grant;
    logic [1:0]        rom_sel;
    logic [ADDR_W-1:0] rom_addr;
    logic              key;
    logic              busy;
    logic              done;

    logic [63:0] rom_bits [4];

    int checks;
    int failures;

    // Model state: a message occupies a window of whole dot units starting at grant cycle m_g.
    int   m_cyc;
    bit   m_valid;
    bit   m_active;
    int   m_owner;
    int   m_g;
    int   m_d;
    int   m_l;
    int   m_ptr;
    int   m_sel;
    logic m_key;
    logic m_done;

    beacon_key_scheduler #(
        .N_REQ    (N_REQ),
        .ADDR_W   (ADDR_W),
        .DIV_W    (DIV_W),
        .GAP_UNITS(GAP_UNITS)
    ) dut (
        .morse_clk(morse_clk),
        .sys_rst  (sys_rst),
        .req      (req),
        .dot_div  (dot_div),
        .msg_last (msg_last),
        .rom_q    (rom_q),
        .grant    (grant),
        .rom_sel  (rom_sel),
        .rom_addr (rom_addr),
        .key      (key),
        .busy     (busy),
        .done     (done)
    );

    assign rom_q = rom_bits[rom_sel][rom_addr];

    initial begin
        morse_clk = 1'b0;
        forever #5 morse_clk = ~morse_clk;
    end

    initial begin
        rom_bits[0] = 64'hA5A5_5A5A_C3C3_3C3C;
        rom_bits[1] = 64'h0000_0000_0000_0075;
        rom_bits[2] = 64'h1234_5678_9ABC_DEF0;
        rom_bits[3] = 64'hFFFF_0000_FFFF_0001;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, wanted %0h", name, m_cyc, act, exp);
        end
    endtask

    // Advance the model to the cycle that starts at this edge.
    always @(posedge morse_clk) begin
        int unit_prev;
        m_cyc++;
        if (sys_rst) begin
            m_valid  = 1'b1;
            m_active = 1'b0;
            m_ptr    = N_REQ - 1;
            m_sel    = 0;
            m_key    = 1'b0;
            m_done   = 1'b0;
        end else begin
            m_key = 1'b0;
            if (m_active) begin
                unit_prev = (m_cyc - 1 - m_g) / (m_d + 1);
                if (unit_prev <= m_l) begin
                    m_key = rom_bits[m_owner][unit_prev];
                end
            end
            m_done = 1'b0;
            if (m_active && m_cyc == m_g + (m_l + 1 + GAP_UNITS) * (m_d + 1)) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end else if (!m_active && req != 4'b0000) begin
                for (int off = 1; off <= N_REQ; off++) begin
                    int idx;
                    idx = (m_ptr + off) % N_REQ;
                    if (!m_active && req[idx]) begin
                        m_active = 1'b1;
                        m_owner  = idx;
                    end
                end
                m_ptr = m_owner;
                m_sel = m_owner;
                m_g   = m_cyc;
                m_d   = int'(dot_div);
                m_l   = int'(msg_last);
            end
        end
    end

    // Compare every output against the model on the falling edge of each cycle.
    always @(negedge morse_clk) begin
        logic [3:0] exp_grant;
        int         unit_now;
        int         exp_addr;
        if (m_valid) begin
            exp_grant = 4'b0000;
            exp_addr  = 0;
            if (m_active) begin
                exp_grant = 4'b0001 << m_owner;
                unit_now  = (m_cyc - m_g) / (m_d + 1);
                exp_addr  = (unit_now > m_l) ? m_l : unit_now;
            end
            checkOutput("model_grant", 32'(grant), 32'(exp_grant));
            checkOutput("model_rom_sel", 32'(rom_sel), 32'(m_sel));
            checkOutput("model_rom_addr", 32'(rom_addr), 32'(exp_addr));
            checkOutput("model_key", 32'(key), 32'(m_key));
            checkOutput("model_busy", 32'(busy), 32'(m_active));
            checkOutput("model_done", 32'(done), 32'(m_done));
        end
    end

    task automatic applyStimulus(input logic rst, input logic [3:0] r,
                                 input logic [DIV_W-1:0] d, input logic [ADDR_W-1:0] l);
        sys_rst  = rst;
        req      = r;
        dot_div  = d;
        msg_last = l;
    endtask

    task automatic waitUntil(input int target);
        while (m_cyc < target) @(negedge morse_clk);
    endtask

    task automatic waitGrant(input string name, input logic [3:0] want, input int limit);
        int n;
        n = 0;
        while (grant !== want && n < limit) begin
            @(negedge morse_clk);
            n++;
        end
        checkOutput(name, 32'(grant), 32'(want));
    endtask

    task automatic waitIdle(input int limit);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < limit) begin
            @(negedge morse_clk);
            n++;
        end
        checkOutput("wait_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [3:0] rr_order [4];
        logic [7:0] key_pattern;
        int         gprev;
        int         g;

        checks   = 0;
        failures = 0;
        m_cyc    = 0;
        m_valid  = 1'b0;
        m_active = 1'b0;
        m_owner  = 0;
        m_g      = 0;
        m_d      = 0;
        m_l      = 0;
        m_ptr    = N_REQ - 1;
        m_sel    = 0;
        m_key    = 1'b0;
        m_done   = 1'b0;

        rr_order[0] = 4'b0010;
        rr_order[1] = 4'b0100;
        rr_order[2] = 4'b1000;
        rr_order[3] = 4'b0001;
        key_pattern = 8'b01110101;

        $display("[TB] reset with all banks requesting");
        applyStimulus(1'b1, 4'b1111, 20'd3, 6'd7);
        repeat (3) @(negedge morse_clk);
        checkOutput("rst_grant", 32'(grant), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_key", 32'(key), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_rom_addr", 32'(rom_addr), 32'd0);
        sys_rst = 1'b0;
        @(negedge morse_clk);
        checkOutput("first_grant", 32'(grant), 32'b0001);
        gprev = m_cyc;

        $display("[TB] round-robin with all banks held");
        for (int k = 0; k < 4; k++) begin
            waitGrant("rr_grant", rr_order[k], 200);
            checkOutput("rr_spacing", 32'(m_cyc - gprev), 32'd61);
            gprev = m_cyc;
        end
        req = 4'b0000;
        waitIdle(200);

        $display("[TB] single message from bank 1 with mid-message withdraw");
        req = 4'b0010;
        waitGrant("single_grant", 4'b0010, 20);
        g = m_cyc;
        for (int i = 0; i < 8; i++) begin
            waitUntil(g + 1 + 4 * i);
            checkOutput("single_key_bit", 32'(key), 32'(key_pattern[i]));
            if (i == 2) begin
                req = 4'b0000;
            end
        end
        waitUntil(g + 59);
        checkOutput("single_done_early", 32'(done), 32'd0);
        waitUntil(g + 60);
        checkOutput("single_done", 32'(done), 32'd1);
        checkOutput("single_done_grant", 32'(grant), 32'd0);
        checkOutput("single_done_busy", 32'(busy), 32'd0);
        waitUntil(g + 65);
        checkOutput("withdraw_no_regrant", 32'(grant), 32'd0);

        $display("[TB] reset in the middle of a message");
        req = 4'b0100;
        waitGrant("midrst_grant", 4'b0100, 20);
        g = m_cyc;
        waitUntil(g + 20);
        applyStimulus(1'b1, 4'b0101, 20'd3, 6'd7);
        @(negedge morse_clk);
        checkOutput("midrst_key", 32'(key), 32'd0);
        checkOutput("midrst_grant_zero", 32'(grant), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        sys_rst = 1'b0;
        @(negedge morse_clk);
        checkOutput("midrst_rearb", 32'(grant), 32'b0001);
        req = 4'b0000;
        waitIdle(200);

        $display("[TB] one-clock dot, single-bit message");
        applyStimulus(1'b0, 4'b1000, 20'd0, 6'd0);
        waitGrant("edge_grant", 4'b1000, 20);
        g = m_cyc;
        req = 4'b0000;
        waitUntil(g + 1);
        checkOutput("edge_key_on", 32'(key), 32'd1);
        waitUntil(g + 2);
        checkOutput("edge_key_off", 32'(key), 32'd0);
        waitUntil(g + 7);
        checkOutput("edge_done_early", 32'(done), 32'd0);
        waitUntil(g + 8);
        checkOutput("edge_done", 32'(done), 32'd1);
        checkOutput("edge_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge morse_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
